ghost_wall_sense: RTL and testbench
===================================

GHOST_WALL_SENSE -- requirements
Module: ghost_wall_sense

Interface
REQ-001 Parameter MAZE_W, default 28, maze width in tiles.
REQ-002 Parameter MAZE_H, default 36, maze height in tiles.
REQ-003 Parameter TUNNEL_ROW, default 19, row on which horizontal wrap-around applies.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  single-cycle pulse requesting a wall lookup for tileX/tileY.
REQ-007 tileX  input  6  ghost tile column, sampled when a request is accepted.
REQ-008 tileY  input  6  ghost tile row, sampled when a request is accepted.
REQ-009 rom_addr  output  10  maze ROM address, combinational from state and latched tile.
REQ-010 rom_data  input  1  maze ROM bit (1 = wall), valid one cycle after rom_addr.
REQ-011 busy  output  1  high while a lookup is in progress.
REQ-012 done  output  1  single-cycle pulse when the wall flags update.
REQ-013 wallUp, wallDown, wallLeft, wallRight  output  1 each  registered wall flags for the tile neighbours (1 = blocked).

Function
REQ-014 States: IDLE, S_UP, S_DN, S_LF, S_RT, S_LAST; transitions IDLE->S_UP on req, then unconditional S_UP->S_DN->S_LF->S_RT->S_LAST->IDLE.
REQ-015 In IDLE with req=1, the block SHALL latch tileX/tileY and enter S_UP; busy SHALL be high in S_UP through S_LAST.
REQ-016 req while busy SHALL be ignored, with no effect on latched tile or sequence.
REQ-017 Address: addr(x,y) = y*MAZE_W + x, computed in 10 bits with no truncation for x<MAZE_W, y<MAZE_H.
REQ-018 rom_addr SHALL be addr(x,y-1) in S_UP, addr(x,y+1) in S_DN, addr(x-1,y) in S_LF, addr(x+1,y) in S_RT, and 0 in IDLE and S_LAST.
REQ-019 rom_data SHALL be captured into a shadow flag in the state following each address state: up in S_DN, down in S_LF, left in S_RT, right in S_LAST.
REQ-020 Forced wall: up when y=0; down when y=MAZE_H-1; left when x=0 and y!=TUNNEL_ROW; right when x=MAZE_W-1 and y!=TUNNEL_ROW.
REQ-021 For a forced wall, the shadow flag SHALL be 1 regardless of rom_data, and rom_addr SHALL be 0 in that address state.
REQ-022 Tunnel wrap on y=TUNNEL_ROW: left of x=0 SHALL read addr(MAZE_W-1,y); right of x=MAZE_W-1 SHALL read addr(0,y).
REQ-023 Invalid tile (x>=MAZE_W or y>=MAZE_H): all four shadow flags SHALL be forced to 1 and rom_addr SHALL stay 0, with unchanged timing.
REQ-024 In S_LAST, all four wall outputs SHALL update simultaneously from the shadow flags and done SHALL be 1 for exactly that cycle.
REQ-025 Latency: req accepted at edge N, done high in the cycle after edge N+5, fixed regardless of tile.
REQ-026 A req in the same cycle done is high SHALL be ignored; a req in the following cycle (IDLE) SHALL be accepted.
REQ-027 Wall outputs SHALL hold their values between lookups.

Reset
REQ-028 On reset: state = IDLE, busy = 0, done = 0, rom_addr = 0, shadow flags = 1, and wallUp/Down/Left/Right = 1 (ghost stationary until the first lookup).
REQ-029 Reset asserted mid-lookup SHALL abort the sequence immediately, with no done pulse and outputs at reset values.

Verification
REQ-030 req with tile (13,16), ROM walls only at 433 and 462 -> rom_addr sequence 433, 489, 460, 462; done 5 cycles after req; U=1, D=0, L=0, R=1.
REQ-031 Tunnel: req with tile (0,19), ROM all 0 -> rom_addr 504, 560, 559, 533; all flags 0. Tile (27,19) -> right-neighbour address 532.
REQ-032 Edge: tile (0,0), ROM all 0 -> U=1, L=1 forced (rom_addr 0 in those states), D=0, R=0.
REQ-033 Invalid tile (30,5) -> rom_addr stays 0, done after 5 cycles, all flags 1.
REQ-034 req pulsed again at cycle +2 of a lookup -> ignored; exactly one done; results reflect the first tile.
REQ-035 reset at cycle +3 of a lookup -> no done; flags read 1; a new req after reset completes normally.

Source files
------------

// File: rtl/ghost_wall_sense.sv
// Probes the four maze neighbours of a ghost tile through a one-cycle-latency
// wall ROM and publishes the registered wall flags with a single done pulse.
module ghost_wall_sense #(
    parameter int MAZE_W     = 28,
    parameter int MAZE_H     = 36,
    parameter int TUNNEL_ROW = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [5:0] tileX,
    input  logic [5:0] tileY,
    output logic [9:0] rom_addr,
    input  logic       rom_data,
    output logic       busy,
    output logic       done,
    output logic       wallUp,
    output logic       wallDown,
    output logic       wallLeft,
    output logic       wallRight,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {IDLE, S_UP, S_DN, S_LF, S_RT, S_LAST} state_t;

    localparam logic [9:0] W10    = 10'(MAZE_W);
    localparam logic [5:0] W_LAST = 6'(MAZE_W - 1);
    localparam logic [5:0] H_LAST = 6'(MAZE_H - 1);
    localparam logic [5:0] T_ROW  = 6'(TUNNEL_ROW);

    state_t     state_q, state_d;
    logic [5:0] tile_x_q, tile_x_d;
    logic [5:0] tile_y_q, tile_y_d;
    logic [3:0] shadow_q, shadow_d;   // {up, down, left, right}
    logic [3:0] wall_q, wall_d;       // {up, down, left, right}
    logic       done_q, done_d;

    logic       tile_valid, tunnel;
    logic       force_up, force_dn, force_lf, force_rt;
    logic [5:0] x_left, x_right;

    function automatic logic [9:0] addr_of(input logic [5:0] x, input logic [5:0] y);
        return ({4'd0, y} * W10) + {4'd0, x};
    endfunction

    always_comb begin
        tile_valid = (tile_x_q <= W_LAST) && (tile_y_q <= H_LAST);
        tunnel     = (tile_y_q == T_ROW);
        force_up   = !tile_valid || (tile_y_q == 6'd0);
        force_dn   = !tile_valid || (tile_y_q == H_LAST);
        force_lf   = !tile_valid || ((tile_x_q == 6'd0) && !tunnel);
        force_rt   = !tile_valid || ((tile_x_q == W_LAST) && !tunnel);
        // Horizontal neighbours wrap; only the tunnel row lets the wrapped address through.
        x_left     = (tile_x_q == 6'd0) ? W_LAST : tile_x_q - 6'd1;
        x_right    = (tile_x_q == W_LAST) ? 6'd0 : tile_x_q + 6'd1;
    end

    always_comb begin
        state_d  = state_q;
        tile_x_d = tile_x_q;
        tile_y_d = tile_y_q;
        shadow_d = shadow_q;
        wall_d   = wall_q;
        done_d   = 1'b0;
        rom_addr = 10'd0;
        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE; a request there is deliberately dropped.
                if (req && !done_q) begin
                    tile_x_d = tileX;
                    tile_y_d = tileY;
                    state_d  = S_UP;
                end
            end
            S_UP: begin
                if (!force_up) rom_addr = addr_of(tile_x_q, tile_y_q - 6'd1);
                state_d = S_DN;
            end
            S_DN: begin
                if (!force_dn) rom_addr = addr_of(tile_x_q, tile_y_q + 6'd1);
                shadow_d[3] = force_up | rom_data;
                state_d     = S_LF;
            end
            S_LF: begin
                if (!force_lf) rom_addr = addr_of(x_left, tile_y_q);
                shadow_d[2] = force_dn | rom_data;
                state_d     = S_RT;
            end
            S_RT: begin
                if (!force_rt) rom_addr = addr_of(x_right, tile_y_q);
                shadow_d[1] = force_lf | rom_data;
                state_d     = S_LAST;
            end
            S_LAST: begin
                shadow_d[0] = force_rt | rom_data;
                wall_d      = {shadow_q[3:1], force_rt | rom_data};
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            tile_x_q <= 6'd0;
            tile_y_q <= 6'd0;
            shadow_q <= 4'hF;
            wall_q   <= 4'hF;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tile_x_q <= tile_x_d;
            tile_y_q <= tile_y_d;
            shadow_q <= shadow_d;
            wall_q   <= wall_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign wallUp    = wall_q[3];
    assign wallDown  = wall_q[2];
    assign wallLeft  = wall_q[1];
    assign wallRight = wall_q[0];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ghost_wall_sense.sv
// Directed bench for ghost_wall_sense: a tile-level neighbour model checked every
// cycle, plus literal expectations for the worked examples.
module tb_ghost_wall_sense;

    localparam int W = 28;
    localparam int H = 36;
    localparam int T = 19;

    logic       clk;
    logic       reset;
    logic       req;
    logic [5:0] tileX, tileY;
    logic [9:0] rom_addr;
    logic       rom_data = 1'b0;
    logic       busy, done;
    logic       wallUp, wallDown, wallLeft, wallRight;
    logic [2:0] dbg_state;

    ghost_wall_sense #(.MAZE_W(W), .MAZE_H(H), .TUNNEL_ROW(T)) dut (
        .clk(clk), .reset(reset), .req(req), .tileX(tileX), .tileY(tileY),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
        .wallUp(wallUp), .wallDown(wallDown), .wallLeft(wallLeft),
        .wallRight(wallRight), .dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Maze ROM with one cycle of read latency
    logic rom_mem [0:1023];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Neighbour rules: dir 0=up 1=down 2=left 3=right; -1 means forced wall.
    function automatic int nb_addr(input int x, input int y, input int dir);
        if (x >= W || y >= H) return -1;
        case (dir)
            0: return (y == 0) ? -1 : (y - 1) * W + x;
            1: return (y == H - 1) ? -1 : (y + 1) * W + x;
            2: if (x == 0) return (y == T) ? y * W + (W - 1) : -1;
               else return y * W + x - 1;
            default: if (x == W - 1) return (y == T) ? y * W : -1;
               else return y * W + x + 1;
        endcase
    endfunction

    function automatic int exp_addr(input int x, input int y, input int dir);
        int a;
        a = nb_addr(x, y, dir);
        return (a < 0) ? 0 : a;
    endfunction

    function automatic logic exp_flag(input int x, input int y, input int dir);
        int a;
        a = nb_addr(x, y, dir);
        return (a < 0) ? 1'b1 : rom_mem[a];
    endfunction

    // Model: m_cnt counts cycles into a lookup (0 = idle)
    int         m_cnt = 0;
    int         m_x = 0, m_y = 0;
    logic       m_done = 1'b0;
    logic [3:0] m_walls = 4'hF;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   = 0;
            m_done  = 1'b0;
            m_walls = 4'hF;
        end else if (m_cnt == 0) begin
            if (req && !m_done) begin
                m_x   = int'(tileX);
                m_y   = int'(tileY);
                m_cnt = 1;
            end
            m_done = 1'b0;
        end else if (m_cnt == 5) begin
            m_cnt   = 0;
            m_done  = 1'b1;
            m_walls = {exp_flag(m_x, m_y, 0), exp_flag(m_x, m_y, 1),
                       exp_flag(m_x, m_y, 2), exp_flag(m_x, m_y, 3)};
        end else begin
            m_cnt++;
        end
    end

    // Scoreboard compare every cycle, away from the active edge
    always @(negedge clk) begin
        #1;
        chk("cmp_busy", busy, (m_cnt != 0));
        chk("cmp_done", done, m_done);
        chk("cmp_addr", rom_addr,
            (m_cnt >= 1 && m_cnt <= 4) ? exp_addr(m_x, m_y, m_cnt - 1) : 0);
        chk("cmp_walls", {wallUp, wallDown, wallLeft, wallRight}, m_walls);
    end

    logic [9:0] obs_addr [4];
    int done_k, done_cnt;

    task automatic rom_clear();
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b0;
    endtask

    task automatic lookup(input int x, input int y, input int repulse_k, input int reset_k);
        tileX = 6'(x);
        tileY = 6'(y);
        req   = 1'b1;
        @(negedge clk);
        req      = 1'b0;
        done_k   = -1;
        done_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 4) obs_addr[k-1] = rom_addr;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == repulse_k) begin
                req = 1'b1; tileX = 6'd0; tileY = 6'd0;
            end else if (k == repulse_k + 1) begin
                req = 1'b0;
            end
            if (k == reset_k) reset = 1'b1;
            else if (k == reset_k + 1) reset = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output int k_out);
        k_out = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin
                k_out = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_addrs(input string name, input int a0, input int a1, input int a2, input int a3);
        chk({name, "_a_up"}, obs_addr[0], a0);
        chk({name, "_a_dn"}, obs_addr[1], a1);
        chk({name, "_a_lf"}, obs_addr[2], a2);
        chk({name, "_a_rt"}, obs_addr[3], a3);
    endtask

    function automatic logic [3:0] walls();
        return {wallUp, wallDown, wallLeft, wallRight};
    endfunction

    int k2;

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        tileX = 6'd0;
        tileY = 6'd0;
        rom_clear();
        repeat (3) @(negedge clk);
        chk("reset_walls", walls(), 4'hF);
        chk("reset_busy", busy, 0);
        chk("reset_addr", rom_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Pin the model against the worked examples
        chk("pin_up_13_16", exp_addr(13, 16, 0), 433);
        chk("pin_rt_27_19", exp_addr(27, 19, 3), 532);
        chk("pin_lf_0_19", exp_addr(0, 19, 2), 559);

        // Interior tile, walls above and to the right
        rom_mem[433] = 1'b1;
        rom_mem[462] = 1'b1;
        lookup(13, 16, -5, -5);
        chk_addrs("mid", 433, 489, 460, 462);
        chk("mid_done_k", done_k, 6);
        chk("mid_walls", walls(), 4'b1001);

        // Tunnel row wraps both sides
        rom_clear();
        lookup(0, 19, -5, -5);
        chk_addrs("tun0", 504, 560, 559, 533);
        chk("tun0_walls", walls(), 4'b0000);
        lookup(27, 19, -5, -5);
        chk_addrs("tun27", 504 + 27, 560 + 27, 558, 532);

        // Top-left corner: up and left forced
        lookup(0, 0, -5, -5);
        chk_addrs("corner", 0, 28, 0, 1);
        chk("corner_walls", walls(), 4'b1010);

        // Out-of-range tile: everything forced, timing unchanged
        lookup(30, 5, -5, -5);
        chk_addrs("inval", 0, 0, 0, 0);
        chk("inval_done_k", done_k, 6);
        chk("inval_walls", walls(), 4'b1111);

        // Bottom-right corner off the tunnel row
        lookup(27, 35, -5, -5);
        chk_addrs("br", 34 * 28 + 27, 0, 35 * 28 + 26, 0);
        chk("br_walls", walls(), 4'b0101);

        // Request while busy is ignored
        rom_mem[433] = 1'b1;
        rom_mem[462] = 1'b1;
        lookup(13, 16, 2, -5);
        chk("rebusy_done_cnt", done_cnt, 1);
        chk("rebusy_done_k", done_k, 6);
        chk("rebusy_walls", walls(), 4'b1001);

        // Reset mid-lookup aborts with no done
        lookup(0, 19, -5, 3);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_walls", walls(), 4'b1111);
        lookup(13, 16, -5, -5);
        chk("after_abort_done_k", done_k, 6);
        chk("after_abort_walls", walls(), 4'b1001);

        // Request during done dropped, the one in the next cycle accepted
        rom_clear();
        rom_mem[433] = 1'b1;
        tileX = 6'd13; tileY = 6'd16; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(k2);
        chk("chain1_done_k", k2, 6);
        chk("chain1_walls", walls(), 4'b1000);
        tileX = 6'd0; tileY = 6'd19; req = 1'b1;
        @(negedge clk);
        chk("chain_idle_busy", busy, 0);
        @(negedge clk);
        req = 1'b0;
        wait_done(k2);
        chk("chain2_done_k", k2, 6);
        chk("chain2_walls", walls(), 4'b0000);

        repeat (4) @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish before 100000");
        $fatal(1);
    end

endmodule
